// File: rtl/cntr_ud_if.sv
// Control/status bundle between a controller FSM and the up/down counter.
interface cntr_ud_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] din;
    logic             ld;
    logic             inc;
    logic             dec;
    logic [WIDTH-1:0] step;
    logic             clr_ovf;
    logic [WIDTH-1:0] cnt;
    logic             eqz;
    logic             atmax;
    logic             tc;
    logic             ovf;

    // Controller side: issues strobes, watches count and flags.
    modport master (
        output din, ld, inc, dec, step, clr_ovf,
        input  cnt, eqz, atmax, tc, ovf
    );

    // Counter side.
    modport slave (
        input  din, ld, inc, dec, step, clr_ovf,
        output cnt, eqz, atmax, tc, ovf
    );
endinterface

// File: rtl/cntr_ud.sv
// Loadable up/down counter with programmable step, wrap/saturate arithmetic,
// terminal-count pulse, sticky over/underflow flag and optional auto-reload.
module cntr_ud #(
    parameter int unsigned WIDTH       = 16,
    parameter bit          SAT         = 1'b0,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    cntr_ud_if.slave   bus
);
    localparam int unsigned EW = WIDTH + 1;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    logic [EW-1:0]    sum_w;
    logic [EW-1:0]    diff_w;
    logic             go_up;
    logic             go_dn;
    logic             step_nz;
    logic             terminal;

    // State registers; reset clears count, shadow and both flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            tc_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            tc_q     <= tc_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state: ld beats inc/dec; inc with dec, or a zero step, holds.
    always_comb begin
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        tc_d     = 1'b0;
        ovf_d    = ovf_q & ~bus.clr_ovf;
        sum_w    = EW'(cnt_q) + EW'(bus.step);
        diff_w   = EW'(cnt_q) - EW'(bus.step);
        go_up    = bus.inc & ~bus.dec;
        go_dn    = bus.dec & ~bus.inc;
        step_nz  = |bus.step;
        terminal = 1'b0;

        if (bus.ld) begin
            cnt_d    = bus.din;
            shadow_d = bus.din;
        end else if (go_up && step_nz) begin
            cnt_d = sum_w[WIDTH-1:0];
            if (sum_w[WIDTH]) begin
                ovf_d = 1'b1;
                if (SAT) begin
                    cnt_d = '1;
                end
            end
        end else if (go_dn && step_nz) begin
            // Borrow out of the extended subtraction means cnt < step.
            terminal = (cnt_q <= bus.step);
            cnt_d    = diff_w[WIDTH-1:0];
            if (diff_w[WIDTH]) begin
                ovf_d = 1'b1;
                if (SAT) begin
                    cnt_d = '0;
                end
            end
            if (terminal) begin
                tc_d = 1'b1;
                if (AUTO_RELOAD) begin
                    cnt_d = shadow_q;
                end
            end
        end
    end

    // Registered count/flags plus the combinational compare outputs.
    assign bus.cnt   = cnt_q;
    assign bus.tc    = tc_q;
    assign bus.ovf   = ovf_q;
    assign bus.eqz   = (cnt_q == '0);
    assign bus.atmax = (cnt_q == '1);
endmodule
